// File: rtl/phase_cal_pkg.sv
// rtl/phase_cal_pkg.sv - state encoding, width default and saturation helper for the phase scheduler
package phase_cal_pkg;

    localparam int PH_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CLEAR   = 3'd2,
        MEASURE = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Clamp a signed value into the range of a w-bit two's complement number (w < 32).
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            sat = hi;
        else if (v < lo)
            sat = lo;
        else
            sat = v;
    endfunction

endpackage

// File: rtl/phase_meas_scheduler_if.sv
// rtl/phase_meas_scheduler_if.sv - control-loop and detector signal bundle; cal_offset exists only with PHASE_CAL_OFFSET_EN
interface phase_meas_scheduler_if #(
    parameter int PH_W = 16
);
    logic                   start;
    logic                   abort;
    logic                   busy;
    logic                   det_clr;
    logic                   det_en;
    logic signed [PH_W-1:0] det_phase;
    logic                   det_valid;
    logic signed [PH_W-1:0] res_phase;
    logic                   res_valid;
    logic                   res_err;
`ifdef PHASE_CAL_OFFSET_EN
    logic signed [PH_W-1:0] cal_offset;

    modport master (
        input  start, abort, det_phase, det_valid, cal_offset,
        output busy, det_clr, det_en, res_phase, res_valid, res_err
    );
    modport slave (
        output start, abort, det_phase, det_valid, cal_offset,
        input  busy, det_clr, det_en, res_phase, res_valid, res_err
    );
`else
    modport master (
        input  start, abort, det_phase, det_valid,
        output busy, det_clr, det_en, res_phase, res_valid, res_err
    );
    modport slave (
        output start, abort, det_phase, det_valid,
        input  busy, det_clr, det_en, res_phase, res_valid, res_err
    );
`endif
endinterface

// File: rtl/phase_avg_acc.sv
// rtl/phase_avg_acc.sv - signed window accumulator with shift-divide; PHASE_CAL_OFFSET_EN adds saturating offset
module phase_avg_acc
    import phase_cal_pkg::*;
#(
    parameter int PH_W     = PH_W_DEF,
    parameter int AVG_LOG2 = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   add,
    input  logic                   load,
    input  logic signed [PH_W-1:0] phase,
`ifdef PHASE_CAL_OFFSET_EN
    input  logic signed [PH_W-1:0] cal_offset,
`endif
    output logic signed [PH_W-1:0] res_phase
);
    localparam int AW = PH_W + AVG_LOG2;

    logic signed [AW-1:0]   acc;
    logic signed [PH_W-1:0] avg;
    logic signed [PH_W-1:0] res_next;

    // The mean of 2^AVG_LOG2 PH_W-bit samples always fits back into PH_W bits.
    assign avg = PH_W'(acc >>> AVG_LOG2);

`ifdef PHASE_CAL_OFFSET_EN
    logic signed [31:0] diff;
    assign diff     = 32'(avg) - 32'(cal_offset);
    assign res_next = PH_W'(sat(diff, PH_W));
`else
    assign res_next = avg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            res_phase <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (add)
                acc <= acc + AW'(phase);
            if (load)
                res_phase <= res_next;
        end
    end
endmodule

// File: rtl/phase_meas_scheduler.sv
// rtl/phase_meas_scheduler.sv - settle/clear/measure/capture sequencer averaging 2^AVG_LOG2 detector windows; option PHASE_CAL_OFFSET_EN
module phase_meas_scheduler
    import phase_cal_pkg::*;
#(
    parameter int SETTLE_CYC = 1000,
    parameter int WIN_CYC    = 50000,
    parameter int TMO_CYC    = 255,
    parameter int AVG_LOG2   = 3,
    parameter int PH_W       = PH_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    phase_meas_scheduler_if.master  bus
);
    localparam int M1   = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int MAXC = (M1 > TMO_CYC) ? M1 : TMO_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int WW   = AVG_LOG2 + 1;
    localparam logic [WW-1:0] LAST_WIN = WW'((1 << AVG_LOG2) - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [WW-1:0] win_cnt;
    logic          busy, det_clr, det_en, res_valid, res_err;

    assign bus.busy      = busy;
    assign bus.det_clr   = det_clr;
    assign bus.det_en    = det_en;
    assign bus.res_valid = res_valid;
    assign bus.res_err   = res_err;

    phase_avg_acc #(.PH_W(PH_W), .AVG_LOG2(AVG_LOG2)) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clr        (bus.abort || state == IDLE),
        .add        (!bus.abort && state == CAPTURE && bus.det_valid),
        .load       (!bus.abort && state == DONE),
        .phase      (bus.det_phase),
`ifdef PHASE_CAL_OFFSET_EN
        .cal_offset (bus.cal_offset),
`endif
        .res_phase  (bus.res_phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            win_cnt   <= '0;
            busy      <= 1'b0;
            det_clr   <= 1'b0;
            det_en    <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            det_clr   <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            if (bus.abort) begin
                state   <= IDLE;
                cnt     <= '0;
                win_cnt <= '0;
                busy    <= 1'b0;
                det_en  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        state <= SETTLE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                    SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) begin
                        state   <= CLEAR;
                        cnt     <= '0;
                        det_clr <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    CLEAR: begin
                        state  <= MEASURE;
                        cnt    <= '0;
                        det_en <= 1'b1;
                    end
                    MEASURE: if (cnt == CW'(WIN_CYC - 1)) begin
                        state  <= CAPTURE;
                        cnt    <= '0;
                        det_en <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    CAPTURE: if (bus.det_valid) begin
                        cnt     <= '0;
                        win_cnt <= win_cnt + 1'b1;
                        if (win_cnt == LAST_WIN) begin
                            state <= DONE;
                        end else begin
                            state   <= CLEAR;
                            det_clr <= 1'b1;
                        end
                    end else if (cnt == CW'(TMO_CYC - 1)) begin
                        // Detector never answered: end the run without a result.
                        state   <= IDLE;
                        cnt     <= '0;
                        win_cnt <= '0;
                        busy    <= 1'b0;
                        res_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    DONE: begin
                        state     <= IDLE;
                        win_cnt   <= '0;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_phase_meas_scheduler.sv
// tb/tb_phase_meas_scheduler.sv - directed bench for phase_meas_scheduler; PHASE_CAL_OFFSET_EN adds the offset case
module tb_phase_meas_scheduler;
    localparam int SETTLE = 4;
    localparam int WIN    = 8;
    localparam int TMO    = 5;
    localparam int L      = 2;
    localparam int PH_W   = 16;
    localparam int LAT    = 1 + SETTLE + (1 << L) * (1 + WIN + 1) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phase_meas_scheduler_if #(.PH_W(PH_W)) bus ();

    phase_meas_scheduler #(
        .SETTLE_CYC(SETTLE), .WIN_CYC(WIN), .TMO_CYC(TMO), .AVG_LOG2(L), .PH_W(PH_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    int ph [4];
    int lat, clr_n, en_n, bad_runs, errs, vals, ab_en, ab_busy, err_busy, end_busy;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a run at the current negedge and watches 70 cycles; cycle k counts from the start cycle.
    task automatic run(input int hold_win, input int abort_at, input int start_at);
        int win, run_len, err_k;
        lat = 0; clr_n = 0; en_n = 0; bad_runs = 0; errs = 0; vals = 0;
        ab_en = -1; ab_busy = -1; err_busy = -1;
        win = -1; run_len = 0; err_k = -10;
        bus.det_valid = 1'b1;
        bus.start = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            bus.start = (k == start_at);
            bus.abort = (k == abort_at);
            if (bus.det_clr) begin
                clr_n++;
                win++;
                if (win < 4) bus.det_phase = PH_W'(ph[win]);
                bus.det_valid = (win != hold_win);
            end
            if (bus.det_en) begin
                en_n++;
                run_len++;
            end else if (run_len != 0) begin
                if (run_len != WIN) bad_runs++;
                run_len = 0;
            end
            if (bus.res_err) begin
                errs++;
                err_k = k;
            end
            if (k == err_k + 1) err_busy = int'(bus.busy);
            if (bus.res_valid) begin
                vals++;
                if (lat == 0) lat = k;
            end
            if (k == abort_at + 1) begin
                ab_en   = int'(bus.det_en);
                ab_busy = int'(bus.busy);
            end
        end
        end_busy = int'(bus.busy);
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.det_valid = 1'b0;
        bus.det_phase = '0;
`ifdef PHASE_CAL_OFFSET_EN
        bus.cal_offset = '0;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_det_clr", int'(bus.det_clr), 0);
        check("rst_det_en", int'(bus.det_en), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_res_err", int'(bus.res_err), 0);
        check("rst_res_phase", int'(bus.res_phase), 0);
        rst = 1'b0;
        @(negedge clk);

        // Constant phase 100 in every window
        ph = '{100, 100, 100, 100};
        run(-1, -1, -1);
        check("t1_res_phase", int'(bus.res_phase), 100);
        check("t1_latency", lat, LAT);
        check("t1_clr_pulses", clr_n, 4);
        check("t1_en_cycles", en_n, 4 * WIN);
        check("t1_bad_windows", bad_runs, 0);
        check("t1_res_valid_cnt", vals, 1);
        check("t1_busy_end", end_busy, 0);

        // Floor rounding of a negative mean: -9/4 -> -3
        ph = '{-3, -2, -2, -2};
        run(-1, -1, -1);
        check("t2_res_phase", int'(bus.res_phase), -3);
        check("t2_res_valid_cnt", vals, 1);

        // Window 2 never gets det_valid
        ph = '{50, 50, 50, 50};
        run(1, -1, -1);
        check("t3_res_err_cnt", errs, 1);
        check("t3_busy_after_err", err_busy, 0);
        check("t3_res_valid_cnt", vals, 0);
        check("t3_clr_pulses", clr_n, 2);
        check("t3_res_phase_held", int'(bus.res_phase), -3);

        // Abort in the third cycle of window 2 measurement, then a clean run
        ph = '{100, 100, 100, 100};
        run(-1, 18, -1);
        check("t4_det_en_after_abort", ab_en, 0);
        check("t4_busy_after_abort", ab_busy, 0);
        check("t4_en_cycles", en_n, WIN + 3);
        check("t4_res_valid_cnt", vals, 0);
        check("t4_res_err_cnt", errs, 0);
        ph = '{20, 20, 20, 20};
        run(-1, -1, -1);
        check("t4_clean_res_phase", int'(bus.res_phase), 20);
        check("t4_clean_latency", lat, LAT);

        // start during a run is dropped
        ph = '{7, 7, 7, 7};
        run(-1, -1, 20);
        check("t5_res_valid_cnt", vals, 1);
        check("t5_clr_pulses", clr_n, 4);
        check("t5_busy_end", end_busy, 0);
        check("t5_res_phase", int'(bus.res_phase), 7);

        // start and abort together in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("t5_sa_busy", int'(bus.busy), 0);
        repeat (SETTLE + 2) @(negedge clk);
        check("t5_sa_no_clr", int'(bus.det_clr), 0);
        check("t5_sa_busy_late", int'(bus.busy), 0);

        // Reset in the middle of a run
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_res_phase", int'(bus.res_phase), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_det_en", int'(bus.det_en), 0);

`ifdef PHASE_CAL_OFFSET_EN
        // 32767 - (-100) saturates at positive full scale
        @(negedge clk);
        bus.cal_offset = -16'sd100;
        ph = '{32767, 32767, 32767, 32767};
        run(-1, -1, -1);
        check("t6_res_phase_sat", int'(bus.res_phase), 32767);
        check("t6_res_valid_cnt", vals, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
